// File: rtl/regfile_bypass_sb.sv
// Parametrised two-read/one-write register file with registered read ports,
// optional hard-wired zero register, optional write-to-read bypass and a busy scoreboard.
module regfile_bypass_sb #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS_EN = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic              enReg,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] BusW,
    input  logic              RegWrite,
    input  logic              SetBusy,
    input  logic [ADDR_W-1:0] BusyAddr,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              BusyA,
    output logic              BusyB
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;

    logic              write_ok;
    logic              set_ok;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              busy_a;
    logic              busy_b;

    assign write_ok = RegWrite && !((ZERO_REG != 0) && (RW == '0));
    assign set_ok   = SetBusy  && !((ZERO_REG != 0) && (BusyAddr == '0));

    // Forwarded busy only reflects the write's clear; a same-edge set shows up on the next read.
    always_comb begin
        val_a  = regs[RA];
        busy_a = busy[RA];
        if ((BYPASS_EN != 0) && write_ok && (RW == RA)) begin
            val_a  = BusW;
            busy_a = 1'b0;
        end
        if ((ZERO_REG != 0) && (RA == '0)) begin
            val_a  = '0;
            busy_a = 1'b0;
        end

        val_b  = regs[RB];
        busy_b = busy[RB];
        if ((BYPASS_EN != 0) && write_ok && (RW == RB)) begin
            val_b  = BusW;
            busy_b = 1'b0;
        end
        if ((ZERO_REG != 0) && (RB == '0)) begin
            val_b  = '0;
            busy_b = 1'b0;
        end
    end

    // The set is assigned after the write's clear so a new producer keeps the register busy.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy  <= '0;
            BusA  <= '0;
            BusB  <= '0;
            BusyA <= 1'b0;
            BusyB <= 1'b0;
        end else begin
            if (write_ok) begin
                regs[RW] <= BusW;
                busy[RW] <= 1'b0;
            end
            if (set_ok) begin
                busy[BusyAddr] <= 1'b1;
            end
            if (enReg) begin
                BusA  <= val_a;
                BusB  <= val_b;
                BusyA <= busy_a;
                BusyB <= busy_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard bench: three register-file configurations share one stimulus stream and are
// checked every cycle against a behavioural model of the register/busy/output contents.
module tb_regfile_bypass_sb;

    logic        Clk;
    logic        rst;
    logic        en;
    logic        we;
    logic        sb;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rw;
    logic [3:0]  sa;
    logic [31:0] w;

    logic [15:0] a0, b0, a1, b1;
    logic [31:0] a2, b2;
    logic [2:0]  ba, bb;

    // cfg0: defaults; cfg1: ZERO_REG=0, BYPASS_EN=0; cfg2: 32-bit data, 16 registers
    regfile_bypass_sb u0 (
        .Clk(Clk), .Rst(rst), .RA(ra[2:0]), .RB(rb[2:0]), .enReg(en),
        .RW(rw[2:0]), .BusW(w[15:0]), .RegWrite(we), .SetBusy(sb), .BusyAddr(sa[2:0]),
        .BusA(a0), .BusB(b0), .BusyA(ba[0]), .BusyB(bb[0])
    );

    regfile_bypass_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS_EN(0)) u1 (
        .Clk(Clk), .Rst(rst), .RA(ra[2:0]), .RB(rb[2:0]), .enReg(en),
        .RW(rw[2:0]), .BusW(w[15:0]), .RegWrite(we), .SetBusy(sb), .BusyAddr(sa[2:0]),
        .BusA(a1), .BusB(b1), .BusyA(ba[1]), .BusyB(bb[1])
    );

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS_EN(1)) u2 (
        .Clk(Clk), .Rst(rst), .RA(ra), .RB(rb), .enReg(en),
        .RW(rw), .BusW(w), .RegWrite(we), .SetBusy(sb), .BusyAddr(sa),
        .BusA(a2), .BusB(b2), .BusyA(ba[2]), .BusyB(bb[2])
    );

    typedef struct packed {
        logic [2:0][31:0] a;
        logic [2:0][31:0] b;
        logic [2:0]       ba;
        logic [2:0]       bb;
    } exp_t;

    exp_t q[$];

    logic [31:0] mreg  [3][16];
    logic        mbusy [3][16];
    logic [31:0] mo_a  [3];
    logic [31:0] mo_b  [3];
    logic        mo_ba [3];
    logic        mo_bb [3];

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic read_val(input int c, input logic [3:0] addr, input logic wr,
                            input logic [3:0] waddr, input logic [31:0] wdata,
                            input bit zero, input bit byp,
                            output logic [31:0] d, output logic bz);
        if (zero && addr == 4'd0) begin
            d  = 32'd0;
            bz = 1'b0;
        end else if (byp && wr && waddr == addr) begin
            d  = wdata;
            bz = 1'b0;
        end else begin
            d  = mreg[c][addr];
            bz = mbusy[c][addr];
        end
    endtask

    task automatic model_edge(input int c);
        logic [3:0]  am;
        logic [31:0] dm;
        bit          zero, byp;
        logic [3:0]  x_ra, x_rb, x_rw, x_sa;
        logic [31:0] x_w;
        logic        wr;
        am   = (c == 2) ? 4'hF : 4'h7;
        dm   = (c == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        zero = (c != 1);
        byp  = (c != 1);
        x_ra = ra & am;
        x_rb = rb & am;
        x_rw = rw & am;
        x_sa = sa & am;
        x_w  = w & dm;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mreg[c][i]  = 32'd0;
                mbusy[c][i] = 1'b0;
            end
            mo_a[c]  = 32'd0;
            mo_b[c]  = 32'd0;
            mo_ba[c] = 1'b0;
            mo_bb[c] = 1'b0;
        end else begin
            wr = we && !(zero && x_rw == 4'd0);
            if (en) begin
                read_val(c, x_ra, wr, x_rw, x_w, zero, byp, mo_a[c], mo_ba[c]);
                read_val(c, x_rb, wr, x_rw, x_w, zero, byp, mo_b[c], mo_bb[c]);
            end
            if (wr) begin
                mreg[c][x_rw]  = x_w;
                mbusy[c][x_rw] = 1'b0;
            end
            if (sb && !(zero && x_sa == 4'd0)) mbusy[c][x_sa] = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] a_ra,
                        input logic [3:0] a_rb, input logic wen, input logic [3:0] a_rw,
                        input logic [31:0] a_w, input logic s, input logic [3:0] a_sa);
        exp_t ex;
        rst = r;  en = e;  ra = a_ra;  rb = a_rb;
        we  = wen; rw = a_rw; w = a_w; sb = s; sa = a_sa;
        for (int c = 0; c < 3; c++) begin
            model_edge(c);
            ex.a[c]  = mo_a[c];
            ex.b[c]  = mo_b[c];
            ex.ba[c] = mo_ba[c];
            ex.bb[c] = mo_bb[c];
        end
        q.push_back(ex);
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input int c, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL cfg%0d %s: got %h expected %h at %0t", c, name, got, exp, $time);
    endtask

    initial begin : monitor
        exp_t             ex;
        logic [2:0][31:0] ga;
        logic [2:0][31:0] gb;
        forever begin
            @(posedge Clk);
            #3;
            if (q.size() > 0) begin
                ex = q.pop_front();
                ga[0] = {16'd0, a0};
                ga[1] = {16'd0, a1};
                ga[2] = a2;
                gb[0] = {16'd0, b0};
                gb[1] = {16'd0, b1};
                gb[2] = b2;
                for (int c = 0; c < 3; c++) begin
                    check("BusA", c, ga[c], ex.a[c]);
                    check("BusB", c, gb[c], ex.b[c]);
                    check("BusyA", c, {31'd0, ba[c]}, {31'd0, ex.ba[c]});
                    check("BusyB", c, {31'd0, bb[c]}, {31'd0, ex.bb[c]});
                end
            end
        end
    end

    function automatic logic [3:0] pick_addr();
        if ($urandom_range(0, 2) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin : driver
        rst = 1'b1; en = 1'b0; we = 1'b0; sb = 1'b0;
        ra = '0; rb = '0; rw = '0; sa = '0; w = '0;
        #1;
        // reset with a write that must be lost
        step(1, 0, 0, 0, 1, 1, 32'h0000_AAAA, 0, 0);
        step(1, 0, 0, 0, 1, 1, 32'h0000_AAAA, 0, 0);
        step(0, 1, 1, 7, 0, 0, 0, 0, 0);
        // write/read and r0 protection
        step(0, 0, 0, 0, 1, 3, 32'h0000_1234, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h0000_FFFF, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0, 0, 0);
        // bypass vs read-before-write
        step(0, 0, 0, 0, 1, 2, 32'h0000_0005, 0, 0);
        step(0, 1, 2, 2, 1, 2, 32'h0000_5555, 0, 0);
        step(0, 1, 2, 2, 0, 0, 0, 0, 0);
        // read hold
        step(0, 1, 3, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 5, 5, 0, 0, 0, 0, 0);
        // scoreboard
        step(0, 0, 0, 0, 0, 0, 0, 1, 4);
        step(0, 1, 4, 4, 0, 0, 0, 0, 0);
        step(0, 1, 4, 4, 1, 4, 32'h0000_00C4, 0, 0);
        step(0, 1, 4, 4, 1, 4, 32'h0000_0BEE, 1, 4);
        step(0, 1, 4, 4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // top register of the wide configuration
        step(0, 0, 0, 0, 1, 15, 32'hDEAD_BEEF, 0, 0);
        step(0, 1, 15, 14, 0, 0, 0, 0, 0);
        // randomized traffic including occasional mid-operation reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), pick_addr(), pick_addr(),
                 $urandom_range(0, 1), pick_addr(), $urandom(), ($urandom_range(0, 3) == 0),
                 pick_addr());
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk);
        #5;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
